// File: rtl/pid_increment.sv
// Incremental (velocity-form) PID stage.
// Computes u(k) = u(k-1) + Q0*e(k) + Q1*e(k-1) + Q2*e(k-2) with one shared
// multiplier over three cycles, saturates to UW bits, and holds the result.
module pid_increment #(
  parameter logic signed [15:0] Q0   = 16'sd384,
  parameter logic signed [15:0] Q1   = -16'sd512,
  parameter logic signed [15:0] Q2   = 16'sd160,
  parameter int                 FRAC = 8,
  parameter int                 UW   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [8:0]    ek,
  output logic signed [UW-1:0] uk,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, M0, M1, M2, SAT} state_t;

  // Output range limits, widened to the accumulator width for comparison.
  localparam logic signed [31:0] U_MAX = (32'sd1 <<< (UW - 1)) - 32'sd1;
  localparam logic signed [31:0] U_MIN = -(32'sd1 <<< (UW - 1));

  state_t                 state;
  state_t                 state_next;
  logic signed [8:0]      e0;
  logic signed [8:0]      e1;
  logic signed [8:0]      e2;
  logic signed [31:0]     acc;
  logic signed [UW-1:0]   u_prev;
  logic signed [15:0]     coef;
  logic signed [8:0]      opnd;
  logic signed [24:0]     prod;
  logic signed [31:0]     acc_shift;
  logic signed [UW-1:0]   sat_val;

  // Pick the coefficient/error pair for the shared multiplier by MAC step.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    coef = Q0;
    opnd = e0;
    case (state)
      M1:      begin coef = Q1; opnd = e1; end
      M2:      begin coef = Q2; opnd = e2; end
      default: begin coef = Q0; opnd = e0; end
    endcase
  end

  // 16x9 signed product always fits in 25 bits, so no overflow here.
  assign prod      = 25'(coef) * 25'(opnd);

  // Arithmetic shift floors toward minus infinity, including negative sums.
  assign acc_shift = acc >>> FRAC;

  // Clamp the rescaled sum into the signed UW-bit output range.
  always_comb begin
    sat_val = acc_shift[UW-1:0];
    if (acc_shift > U_MAX) begin
      sat_val = U_MAX[UW-1:0];
    end else if (acc_shift < U_MIN) begin
      sat_val = U_MIN[UW-1:0];
    end
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state sequencing: accept in IDLE, three MAC steps, then saturate.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = M0;
      M0:      state_next = M1;
      M1:      state_next = M2;
      M2:      state_next = SAT;
      SAT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, accumulation, and history/output update.
  // History and u_prev change only in SAT, so an aborted run leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0     <= '0;
      e1     <= '0;
      e2     <= '0;
      acc    <= '0;
      u_prev <= '0;
      uk     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            e0  <= ek;
            acc <= 32'(u_prev) <<< FRAC;
          end
        end
        M0, M1, M2: begin
          acc <= acc + 32'(prod);
        end
        SAT: begin
          // Anti-windup: the stored previous output is the clamped value.
          uk     <= sat_val;
          u_prev <= sat_val;
          e2     <= e1;
          e1     <= e0;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
